// File: rtl/dcache_pkg.sv
// Shared types and defaults for the strided tile data cache.
//   state_e     : request FSM encoding
//   DEF_*       : default geometry (tile side, bank count, element width, depth)
//   addr_w()    : element address width from bank/depth logs
//   lanes()     : lanes per tile
//   lane_idx_w(): bits needed to name one lane of a tile
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

    localparam int unsigned DEF_SZ        = 4;
    localparam int unsigned DEF_LOGCNT    = 5;
    localparam int unsigned DEF_BITS      = 18;
    localparam int unsigned DEF_DEPTH_LOG = 10;
    localparam int unsigned DEF_ADDR_W    = DEF_LOGCNT + DEF_DEPTH_LOG;
    localparam int unsigned DEF_LANES     = DEF_SZ * DEF_SZ;

    function automatic int unsigned addr_w(input int unsigned logcnt, input int unsigned depth_log);
        return logcnt + depth_log;
    endfunction

    function automatic int unsigned lanes(input int unsigned sz);
        return sz * sz;
    endfunction

    function automatic int unsigned lane_idx_w(input int unsigned sz);
        return (sz * sz > 1) ? $clog2(sz * sz) : 1;
    endfunction

endpackage

// File: rtl/dcache_bank.sv
// Single-port BRAM bank with registered read.
//   clk   : clock
//   en    : access this cycle
//   we    : 1 = write wdata to addr, 0 = read addr (data valid next cycle)
//   addr  : row address
//   wdata : write data
//   rdata : read data, holds its value on writes and idle cycles
module dcache_bank
    import dcache_pkg::*;
#(
    parameter int unsigned BITS      = DEF_BITS,
    parameter int unsigned DEPTH_LOG = DEF_DEPTH_LOG
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] addr,
    input  logic [BITS-1:0]      wdata,
    output logic [BITS-1:0]      rdata
);

    logic [BITS-1:0] mem_q [1 << DEPTH_LOG];
    logic [BITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/strided_tile_dcache.sv
// Banked tile port: one request reads or writes an SZ x SZ tile whose lane
// (y,x) lives at addr + stride_x*x + stride_y*y (mod 2^ADDR_W). Lanes that
// collide on a bank are issued over successive cycles, lowest lane first.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : request handshake, ready only when idle
//   req_we            : 1 = tile write, 0 = tile read
//   req_addr/stride_* : base address and per-axis strides
//   req_wdata         : write tile, lane l at [BITS*l +: BITS]
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : read tile, held between responses
//   stall_cycles      : saturating count of extra issue rounds
module strided_tile_dcache
    import dcache_pkg::*;
#(
    parameter  int unsigned SZ        = DEF_SZ,
    parameter  int unsigned LOGCNT    = DEF_LOGCNT,
    parameter  int unsigned BITS      = DEF_BITS,
    parameter  int unsigned DEPTH_LOG = DEF_DEPTH_LOG,
    localparam int unsigned ADDR_W    = addr_w(LOGCNT, DEPTH_LOG),
    localparam int unsigned LANES     = lanes(SZ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [ADDR_W-1:0]       req_stride_x,
    input  logic [ADDR_W-1:0]       req_stride_y,
    input  logic [BITS*LANES-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [BITS*LANES-1:0]   resp_rdata,
    output logic [15:0]             stall_cycles
);

    localparam int unsigned CNT = 1 << LOGCNT;
    localparam int unsigned LW  = lane_idx_w(SZ);

    state_e                 state_q, state_d;
    logic [LANES-1:0]       pending_q, pending_d;
    logic                   we_q, we_d;
    logic [BITS*LANES-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0]      lane_addr_q [LANES];
    logic [ADDR_W-1:0]      lane_addr_d [LANES];
    logic                   first_q, first_d;
    logic [15:0]            stall_q, stall_d;
    logic [CNT-1:0]         ret_valid_q, ret_valid_d;
    logic [LW-1:0]          ret_lane_q [CNT];
    logic [LW-1:0]          ret_lane_d [CNT];
    logic [BITS*LANES-1:0]  rdata_q, rdata_d;

    logic [LANES-1:0]       grant;
    logic [CNT-1:0]         bank_en;
    logic [LW-1:0]          bank_lane  [CNT];
    logic [DEPTH_LOG-1:0]   bank_row   [CNT];
    logic [BITS-1:0]        bank_wdata [CNT];
    logic [BITS-1:0]        bank_rdata [CNT];

    // A pending lane is granted unless a lower pending lane targets the same
    // bank; this yields exactly one lowest-index grant per busy bank.
    always_comb begin
        grant   = '0;
        bank_en = '0;
        for (int unsigned b = 0; b < CNT; b++) begin
            bank_lane[b]  = '0;
            bank_row[b]   = '0;
            bank_wdata[b] = '0;
        end
        if (state_q == ISSUE) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                grant[l] = pending_q[l];
                for (int unsigned j = 0; j < l; j++) begin
                    if (pending_q[j] && lane_addr_q[j][LOGCNT-1:0] == lane_addr_q[l][LOGCNT-1:0]) begin
                        grant[l] = 1'b0;
                    end
                end
            end
        end
        for (int unsigned b = 0; b < CNT; b++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (grant[l] && lane_addr_q[l][LOGCNT-1:0] == LOGCNT'(b)) begin
                    bank_en[b]    = 1'b1;
                    bank_lane[b]  = LW'(l);
                    bank_row[b]   = lane_addr_q[l][ADDR_W-1:LOGCNT];
                    bank_wdata[b] = wdata_q[BITS*l +: BITS];
                end
            end
        end
    end

    for (genvar b = 0; b < CNT; b++) begin : g_bank
        dcache_bank #(
            .BITS      (BITS),
            .DEPTH_LOG (DEPTH_LOG)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[b]),
            .we    (we_q),
            .addr  (bank_row[b]),
            .wdata (bank_wdata[b]),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        first_d     = first_q;
        stall_d     = stall_q;
        rdata_d     = rdata_q;
        ret_valid_d = bank_en & {CNT{~we_q}};
        for (int unsigned b = 0; b < CNT; b++) begin
            ret_lane_d[b] = bank_lane[b];
        end
        for (int unsigned y = 0; y < SZ; y++) begin
            for (int unsigned x = 0; x < SZ; x++) begin
                lane_addr_d[y*SZ+x] = lane_addr_q[y*SZ+x];
            end
        end

        // Read data from last cycle's grants lands in the lane each bank served.
        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned b = 0; b < CNT; b++) begin
                if (ret_valid_q[b] && ret_lane_q[b] == LW'(l)) begin
                    rdata_d[BITS*l +: BITS] = bank_rdata[b];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    wdata_d   = req_wdata;
                    pending_d = '1;
                    first_d   = 1'b1;
                    for (int unsigned y = 0; y < SZ; y++) begin
                        for (int unsigned x = 0; x < SZ; x++) begin
                            lane_addr_d[y*SZ+x] = req_addr + req_stride_x * ADDR_W'(x)
                                                           + req_stride_y * ADDR_W'(y);
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pending_d = pending_q & ~grant;
                first_d   = 1'b0;
                if (!first_q && stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
                if (pending_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            first_q     <= 1'b0;
            stall_q     <= '0;
            ret_valid_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            first_q     <= first_d;
            stall_q     <= stall_d;
            ret_valid_q <= ret_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    // Request payload and grant bookkeeping are only meaningful while
    // pending/ret_valid say so, so they carry no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        wdata_q <= wdata_d;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_addr_q[l] <= lane_addr_d[l];
        end
        for (int unsigned b = 0; b < CNT; b++) begin
            ret_lane_q[b] <= ret_lane_d[b];
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = rdata_q;
    assign stall_cycles = stall_q;

endmodule
